alu_result_select_pipe: RTL
===========================

// Module: alu_result_select_pipe
// PURPOSE
//  Parametrised, pipelined successor to the Mini_ALU result selector. Picks one of NUM_FN operation
//  results by func and derives overflow, zero and illegal-func flags. Registers the outcome behind a
//  2-entry skid buffer with valid/ready on both sides. Sits between the ALU operation units and the
//  register writeback/display stage.
// PARAMETERS
//  WIDTH   6  result width in bits
//  NUM_FN  8  number of operation results, >=2
//  FN_W    3  func width, >= $clog2(NUM_FN)
//  ADD_FN  6  func code whose overflow comes from of_add
//  SUB_FN  7  func code whose overflow comes from of_sub
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            asynchronous, active-high reset
//  res_bus    in   NUM_FN*WIDTH result k at [k*WIDTH +: WIDTH]
//  of_add     in   1            overflow of A+B
//  of_sub     in   1            overflow of A-B
//  func       in   FN_W         operation select
//  in_valid   in   1            upstream data valid
//  in_ready   out  1            block can accept (registered)
//  out_valid  out  1            result/flags valid
//  out_ready  in   1            downstream accepts
//  result     out  WIDTH        selected result
//  overflow   out  1            overflow for this result
//  zero       out  1            result == 0
//  bad_fn     out  1            func >= NUM_FN was presented
//  sticky_clr in   1            clear sticky_of (macro only)
//  sticky_of  out  1            accumulated overflow (macro only)
// BEHAVIOUR
//  - Reset (async assert, sync release): in_ready=1, out_valid=0, result=0, overflow/zero/bad_fn=0,
//    sticky_of=0, both skid entries empty. Reset mid-transfer drops all held data silently.
//  - Select: func<NUM_FN -> res_bus[func]. func>=NUM_FN -> res_bus[ADD_FN], overflow=0, bad_fn=1.
//  - overflow = of_add if func==ADD_FN, of_sub if func==SUB_FN, else 0. zero computed on selected value.
//  - Transfer happens on in_valid&in_ready (upstream) and out_valid&out_ready (downstream).
//  - Latency: 1 cycle from accept to out_valid when output stage is empty. In-order delivery, no loss,
//    no duplication. Output is held stable while out_valid & !out_ready.
//  - Skid: states EMPTY (out stage empty), ONE (out stage full), TWO (out+skid full).
//    EMPTY --accept--> ONE. ONE --accept & !drain--> TWO. ONE --drain & !accept--> EMPTY.
//    ONE --accept & drain--> ONE with new data. TWO --drain--> ONE, skid moves to out stage.
//  - in_ready = (state != TWO), driven from a flop. No combinational path out_ready->in_ready.
//  - Full: in TWO, in_valid is ignored. Upstream must hold its data.
// CONFIGURATION
//  STICKY_OF_EN defined: sticky_of sets on each downstream transfer with overflow=1.
//    sticky_clr clears it; simultaneous set and clear -> set wins.
//  Not defined: sticky_clr is ignored, sticky_of is tied to 0, no extra flops.
// STRUCTURE
//  Package alu_pkg: fn code localparams (FN_A=0, FN_B, FN_NEG_A, FN_NEG_B, FN_GE, FN_XOR, FN_ADD=6,
//  FN_SUB=7), typedef alu_flags_t {overflow, zero, bad_fn}.
//  Sub-module alu_skid_buf #(DW): generic 2-entry valid/ready skid buffer carrying {result, flags}.
//  Top level: combinational select/flag logic + one alu_skid_buf + optional sticky flop.
// TESTING (WIDTH=6, NUM_FN=8)
//  1. res_bus k=k+10, func=5, out_ready=1 -> next cycle out_valid=1, result=15, overflow=0, zero=0.
//  2. func=6, of_add=1, res6=0 -> result=0, overflow=1, zero=1. func=7, of_sub=1 -> overflow=1.
//  3. out_ready=0, push 3 beats -> in_ready drops after beat 2, beat 3 is held.
//     Release -> beats appear in order 1,2,3 with no gaps while out_ready=1.
//  4. Continuous in_valid=1/out_ready=1 for 20 beats -> one result per cycle, in_ready never drops.
//  5. NUM_FN=6, func=7 -> bad_fn=1, result=res_bus[6*WIDTH... clamps to ADD_FN result], overflow=0.
//  6. Assert rst while state=TWO -> out_valid=0, in_ready=1 immediately. With STICKY_OF_EN:
//     overflow beat sets sticky_of, sticky_clr clears it, clear in the same cycle as a set keeps it 1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU result-select pipeline.
//   - Function-code localparams matching the Mini_ALU operation order.
//   - alu_flags_t: flag bundle that travels with each result.
//   - skid_state_t: occupancy states of the 2-entry skid buffer.
//   - clamp_fn(): maps a function code onto a valid result index.
package alu_pkg;

  localparam int FN_A     = 0;
  localparam int FN_B     = 1;
  localparam int FN_NEG_A = 2;
  localparam int FN_NEG_B = 3;
  localparam int FN_GE    = 4;
  localparam int FN_XOR   = 5;
  localparam int FN_ADD   = 6;
  localparam int FN_SUB   = 7;

  typedef struct packed {
    logic overflow;
    logic zero;
    logic bad_fn;
  } alu_flags_t;

  localparam int FLAGS_W = $bits(alu_flags_t);

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

  // Index used for an illegal func. Normally the ADD slot; if a narrow
  // configuration has no ADD slot, fall back to the highest valid slot.
  function automatic int clamp_fn(input int fn, input int num_fn);
    return (fn < num_fn) ? fn : num_fn - 1;
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// alu_skid_buf: generic 2-entry valid/ready skid buffer.
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset (drops all held data)
//   in_data   in   DW-bit payload from upstream
//   in_valid  in   upstream payload valid
//   in_ready  out  buffer can accept; driven straight from a flop
//   out_data  out  DW-bit payload to downstream (zero after reset)
//   out_valid out  output stage holds data
//   out_ready in   downstream accepts
// The output stage is the primary register; the skid register only fills
// when a beat is accepted while the output stage is stalled. in_ready is a
// registered function of the next state, so out_ready never reaches
// in_ready combinationally.
module alu_skid_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);
  import alu_pkg::*;

  skid_state_t   state_q;
  skid_state_t   state_nxt;
  logic          in_ready_q;
  logic [DW-1:0] out_data_p1;
  logic [DW-1:0] skid_data_p1;
  logic          accept;
  logic          drain;
  logic          load_out_in;
  logic          load_out_skid;
  logic          load_skid;

  assign accept    = in_valid & in_ready_q;
  assign out_valid = (state_q != SKID_EMPTY);
  assign drain     = out_valid & out_ready;
  assign in_ready  = in_ready_q;
  assign out_data  = out_data_p1;

  always_comb begin
    state_nxt     = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          load_out_in = 1'b1;
          state_nxt   = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && drain) begin
          load_out_in = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = SKID_TWO;
        end else if (drain) begin
          state_nxt = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        // in_ready is low here, so no accept can coincide with the drain.
        if (drain) begin
          load_out_skid = 1'b1;
          state_nxt     = SKID_ONE;
        end
      end
      default: state_nxt = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SKID_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_nxt;
      in_ready_q <= (state_nxt != SKID_TWO);
    end
  end

  // ---- stage p1: output register (cleared on reset so the idle output is zero)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_p1 <= '0;
    end else if (load_out_in) begin
      out_data_p1 <= in_data;
    end else if (load_out_skid) begin
      out_data_p1 <= skid_data_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_data_p1 <= in_data;
    end
  end

endmodule

// File: rtl/alu_result_select_pipe.sv
// alu_result_select_pipe: pipelined ALU result selector.
// Selects one of NUM_FN operation results by func, derives overflow, zero
// and illegal-func flags, and registers them behind a 2-entry skid buffer.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   res_bus    in   NUM_FN*WIDTH, result k at [k*WIDTH +: WIDTH]
//   of_add     in   overflow of A+B
//   of_sub     in   overflow of A-B
//   func       in   FN_W operation select
//   in_valid   in   upstream data valid
//   in_ready   out  block can accept (registered)
//   out_valid  out  result/flags valid
//   out_ready  in   downstream accepts
//   result     out  WIDTH selected result
//   overflow   out  overflow for this result
//   zero       out  result == 0
//   bad_fn     out  func >= NUM_FN was presented
//   sticky_clr in   clear sticky_of (only with STICKY_OF_EN)
//   sticky_of  out  accumulated overflow (only with STICKY_OF_EN, else 0)
// Build option: define STICKY_OF_EN to add the sticky overflow flop.
module alu_result_select_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int NUM_FN = 8,
  parameter int FN_W   = 3,
  parameter int ADD_FN = FN_ADD,
  parameter int SUB_FN = FN_SUB
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_FN*WIDTH-1:0] res_bus,
  input  logic                    of_add,
  input  logic                    of_sub,
  input  logic [FN_W-1:0]         func,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        result,
  output logic                    overflow,
  output logic                    zero,
  output logic                    bad_fn,
  input  logic                    sticky_clr,
  output logic                    sticky_of
);

  localparam int DW      = WIDTH + FLAGS_W;
  localparam int BAD_IDX = clamp_fn(ADD_FN, NUM_FN);
  localparam bit ADD_OK  = (ADD_FN < NUM_FN);
  localparam bit SUB_OK  = (SUB_FN < NUM_FN);

  logic             fn_ok_p0;
  logic [WIDTH-1:0] sel_p0;
  alu_flags_t       flags_p0;
  logic [DW-1:0]    out_data_p1;
  alu_flags_t       flags_p1;

  // ---- stage p0: combinational select and flag derivation
  always_comb begin
    fn_ok_p0 = ({1'b0, func} < (FN_W+1)'(NUM_FN));
    sel_p0   = res_bus[BAD_IDX*WIDTH +: WIDTH];
    for (int k = 0; k < NUM_FN; k++) begin
      if (func == FN_W'(k)) begin
        sel_p0 = res_bus[k*WIDTH +: WIDTH];
      end
    end
    flags_p0.overflow = 1'b0;
    if (ADD_OK && fn_ok_p0 && (func == FN_W'(ADD_FN))) begin
      flags_p0.overflow = of_add;
    end else if (SUB_OK && fn_ok_p0 && (func == FN_W'(SUB_FN))) begin
      flags_p0.overflow = of_sub;
    end
    flags_p0.zero   = (sel_p0 == '0);
    flags_p0.bad_fn = ~fn_ok_p0;
  end

  // ---- stage p1: skid-buffered output register
  alu_skid_buf #(
    .DW(DW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  ({sel_p0, flags_p0}),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data_p1),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign result   = out_data_p1[DW-1 -: WIDTH];
  assign flags_p1 = alu_flags_t'(out_data_p1[FLAGS_W-1:0]);
  assign overflow = flags_p1.overflow;
  assign zero     = flags_p1.zero;
  assign bad_fn   = flags_p1.bad_fn;

`ifdef STICKY_OF_EN
  logic sticky_q;

  // A set (overflow beat leaving the block) takes priority over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (out_valid && out_ready && flags_p1.overflow) begin
      sticky_q <= 1'b1;
    end else if (sticky_clr) begin
      sticky_q <= 1'b0;
    end
  end

  assign sticky_of = sticky_q;
`else
  logic sticky_clr_unused;

  assign sticky_clr_unused = sticky_clr;
  assign sticky_of         = 1'b0;
`endif

endmodule
